// File: rtl/skeeball_game_ctrl.sv
// skeeball_game_ctrl: one-game skeeball controller (score, balls, time, game-over hold)
module skeeball_game_ctrl #(
  parameter int unsigned NUM_BALLS = 9,
  parameter int unsigned GAME_SECS = 60,
  parameter int unsigned HOLD_SECS = 5,
  parameter int unsigned SCORE_W   = 10,
  parameter int unsigned PTS0      = 10,
  parameter int unsigned PTS1      = 20,
  parameter int unsigned PTS2      = 30,
  parameter int unsigned PTS3      = 40,
  parameter int unsigned PTS4      = 50
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               clk1Hz,
  input  logic               start,
  input  logic [4:0]         hole,
  input  logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         balls_left,
  output logic [6:0]         time_left,
  output logic [1:0]         state,
  output logic               gate_open,
  output logic               game_over
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10, BAD = 2'b11} state_t;
  localparam logic [31:0] SMAX = (32'd1 << SCORE_W) - 32'd1;
  state_t state_q, state_d;
  logic [7:0] in_w, s1_q, s2_q, s3_q, ev;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0] balls_q, balls_d;
  logic [6:0] time_q, time_d;
  logic tick, start_e, ball;
  logic [4:0] hole_e;
  logic [31:0] pts;
  // input bundle: {miss, hole[4:0], start, clk1Hz}; ev is the rising edge after 2-flop sync
  assign in_w = {miss, hole, start, clk1Hz};
  assign ev = s2_q & ~s3_q;
  assign tick = ev[0];
  assign start_e = ev[1];
  assign hole_e = ev[6:2];
  assign ball = |ev[7:2];
  assign pts = hole_e[4] ? PTS4 : hole_e[3] ? PTS3 : hole_e[2] ? PTS2 :
               hole_e[1] ? PTS1 : hole_e[0] ? PTS0 : 32'd0;
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      score_q <= '0;
      balls_q <= '0;
      time_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q <= in_w;
      s2_q <= s1_q;
      s3_q <= s2_q;
      score_q <= score_d;
      balls_q <= balls_d;
      time_q <= time_d;
    end
  end
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    balls_d = balls_q;
    time_d = time_q;
    case (state_q)
      IDLE: if (start_e) begin
        state_d = PLAY;
        score_d = '0;
        balls_d = 4'(NUM_BALLS);
        time_d = 7'(GAME_SECS);
      end
      PLAY: begin
        if (ball) begin
          balls_d = balls_q - 4'd1;
          score_d = (32'(score_q) + pts > SMAX) ? SCORE_W'(SMAX) : SCORE_W'(32'(score_q) + pts);
        end
        if (tick) time_d = time_q - 7'd1;
        if ((ball && balls_d == 4'd0) || (tick && time_d == 7'd0)) begin
          state_d = OVER;
          time_d = 7'(HOLD_SECS);
        end
      end
      OVER: if (tick) begin
        time_d = time_q - 7'd1;
        if (time_d == 7'd0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        score_d = '0;
        balls_d = '0;
        time_d = '0;
      end
    endcase
  end
  assign score = score_q;
  assign balls_left = balls_q;
  assign time_left = time_q;
  assign state = state_q;
  assign gate_open = state_q == PLAY;
  assign game_over = state_q == OVER;
endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// tb_skeeball_game_ctrl: randomized bench with a behavioural game model, two parameterisations
module tb_skeeball_game_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] in_v = 8'h00;
  logic [9:0] sc_a;
  logic [5:0] sc_b;
  logic [3:0] bl_a, bl_b;
  logic [6:0] tl_a, tl_b;
  logic [1:0] st_a, st_b;
  logic go_a, go_b, ov_a, ov_b;
  logic [24:0] va, vb;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  skeeball_game_ctrl u_a (
    .CLOCK_50(clk), .Reset(rst_n), .clk1Hz(in_v[0]), .start(in_v[1]), .hole(in_v[6:2]),
    .miss(in_v[7]), .score(sc_a), .balls_left(bl_a), .time_left(tl_a), .state(st_a),
    .gate_open(go_a), .game_over(ov_a));
  skeeball_game_ctrl #(.GAME_SECS(3), .SCORE_W(6)) u_b (
    .CLOCK_50(clk), .Reset(rst_n), .clk1Hz(in_v[0]), .start(in_v[1]), .hole(in_v[6:2]),
    .miss(in_v[7]), .score(sc_b), .balls_left(bl_b), .time_left(tl_b), .state(st_b),
    .gate_open(go_b), .game_over(ov_b));
  assign va = {st_a, sc_a, bl_a, tl_a, go_a, ov_a};
  assign vb = {st_b, 4'b0000, sc_b, bl_b, tl_b, go_b, ov_b};
  typedef struct { int st; int score; int balls; int tl; } m_t;
  m_t ma, mb;
  logic [7:0] p1, p2, p3;
  function automatic m_t step(input m_t m, input logic [7:0] e, input int gs, input int smax);
    m_t r;
    int hi;
    bit ball;
    r = m;
    hi = -1;
    for (int i = 0; i < 5; i++) if (e[2+i]) hi = i;
    ball = (hi >= 0) || e[7];
    if (m.st == 0) begin
      if (e[1]) begin r.st = 1; r.score = 0; r.balls = 9; r.tl = gs; end
    end else if (m.st == 1) begin
      if (ball) begin
        r.balls = m.balls - 1;
        if (hi >= 0) r.score = (m.score + 10 * (hi + 1) > smax) ? smax : m.score + 10 * (hi + 1);
      end
      if (e[0]) r.tl = m.tl - 1;
      if (r.balls == 0 || r.tl == 0) begin r.st = 2; r.tl = 5; end
    end else if (e[0]) begin
      r.tl = m.tl - 1;
      if (r.tl == 0) r.st = 0;
    end
    return r;
  endfunction
  function automatic logic [24:0] expv(input m_t m);
    return {2'(m.st), 10'(m.score), 4'(m.balls), 7'(m.tl), m.st == 1, m.st == 2};
  endfunction
  // an input sampled high at edge N-2 and low at N-3 is an event acting at edge N
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{0, 0, 0, 0};
      mb <= '{0, 0, 0, 0};
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
    end else begin
      ma <= step(ma, p2 & ~p3, 60, 1023);
      mb <= step(mb, p2 & ~p3, 3, 63);
      p3 <= p2;
      p2 <= p1;
      p1 <= in_v;
    end
  end
  task automatic do_reset();
    @(negedge clk);
    in_v = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic pulse(input logic [7:0] b, input int hi, input int lo);
    @(negedge clk);
    in_v = in_v | b;
    repeat (hi) @(negedge clk);
    in_v = in_v & ~b;
    repeat (lo) @(negedge clk);
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (va !== 25'd0 || vb !== 25'd0) begin errors++; $display("FAIL reset_state a=%h b=%h exp=0", va, vb); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (va !== 25'd0 || vb !== 25'd0) begin errors++; $display("FAIL reset_release a=%h b=%h exp=0", va, vb); end
    pulse(8'h02, 1, 3);
    pulse(8'h40, 1, 3);
    checks++;
    if (sc_a !== 10'd50 || st_a !== 2'b01) begin errors++; $display("FAIL reset_pregame score=%0d st=%0d exp 50/1", sc_a, st_a); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checks++;
    if (va !== 25'd0 || vb !== 25'd0) begin errors++; $display("FAIL reset_async a=%h b=%h exp=0", va, vb); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (va !== 25'd0 || va !== expv(ma) || vb !== expv(mb)) begin errors++; $display("FAIL reset_noevent a=%h b=%h exp=0", va, vb); end
  endtask
  task automatic test_scoring();
    logic [7:0] pat [3] = '{8'h40, 8'h04, 8'h80};
    int es [3] = '{50, 60, 60};
    int eb [3] = '{8, 7, 6};
    do_reset();
    in_v[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (st_a !== 2'b00) begin errors++; $display("FAIL start_lat1 st=%0d exp=0", st_a); end
    @(negedge clk);
    checks++;
    if (st_a !== 2'b00) begin errors++; $display("FAIL start_lat2 st=%0d exp=0", st_a); end
    @(negedge clk);
    checks++;
    if (st_a !== 2'b01 || bl_a !== 4'd9 || tl_a !== 7'd60 || go_a !== 1'b1 || sc_a !== 10'd0)
      begin errors++; $display("FAIL start_play st=%0d balls=%0d time=%0d gate=%b exp 1/9/60/1", st_a, bl_a, tl_a, go_a); end
    in_v[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse(pat[i], 1, 3);
      checks++;
      if (32'(sc_a) !== es[i] || 32'(bl_a) !== eb[i]) begin errors++; $display("FAIL scoring_%0d score=%0d balls=%0d exp %0d/%0d", i, sc_a, bl_a, es[i], eb[i]); end
      checks++;
      if (va !== expv(ma) || vb !== expv(mb)) begin errors++; $display("FAIL scoring_model_%0d a=%h/%h b=%h/%h", i, va, expv(ma), vb, expv(mb)); end
    end
  endtask
  task automatic test_ball_limit();
    int held;
    int b;
    for (int i = 0; i < 6; i++) begin
      b = $urandom_range(0, 5);
      pulse(b == 5 ? 8'h80 : 8'h04 << b, 1 + $urandom_range(0, 3), 3);
      checks++;
      if (va !== expv(ma) || vb !== expv(mb)) begin errors++; $display("FAIL balls_model_%0d a=%h/%h b=%h/%h", i, va, expv(ma), vb, expv(mb)); end
    end
    checks++;
    if (st_a !== 2'b10 || bl_a !== 4'd0 || go_a !== 1'b0 || ov_a !== 1'b1 || tl_a !== 7'd5)
      begin errors++; $display("FAIL balls_over st=%0d balls=%0d gate=%b over=%b time=%0d exp 2/0/0/1/5", st_a, bl_a, go_a, ov_a, tl_a); end
    held = ma.score;
    for (int i = 0; i < 5; i++) begin
      pulse(8'h01, 2, 3);
      checks++;
      if (va !== expv(ma) || vb !== expv(mb)) begin errors++; $display("FAIL hold_model_%0d a=%h/%h b=%h/%h", i, va, expv(ma), vb, expv(mb)); end
    end
    checks++;
    if (st_a !== 2'b00 || ov_a !== 1'b0 || 32'(sc_a) !== held) begin errors++; $display("FAIL hold_idle st=%0d over=%b score=%0d exp 0/0/%0d", st_a, ov_a, sc_a, held); end
  endtask
  task automatic test_timeout();
    int et [3] = '{2, 1, 5};
    int es [3] = '{1, 1, 2};
    do_reset();
    pulse(8'h02, 1, 3);
    checks++;
    if (tl_b !== 7'd3 || st_b !== 2'b01) begin errors++; $display("FAIL timeout_start time=%0d st=%0d exp 3/1", tl_b, st_b); end
    for (int i = 0; i < 3; i++) begin
      pulse(8'h01, 1 + $urandom_range(0, 4), 3);
      checks++;
      if (32'(tl_b) !== et[i] || 32'(st_b) !== es[i]) begin errors++; $display("FAIL timeout_%0d time=%0d st=%0d exp %0d/%0d", i, tl_b, st_b, et[i], es[i]); end
    end
    checks++;
    if (tl_a !== 7'd57 || st_a !== 2'b01 || va !== expv(ma)) begin errors++; $display("FAIL timeout_long time=%0d st=%0d exp 57/1", tl_a, st_a); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    pulse(8'h02, 1, 3);
    @(negedge clk);
    in_v = 8'h80 | 8'h40 | 8'h08 | 8'h04;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (va !== expv(ma) || vb !== expv(mb)) begin errors++; $display("FAIL simul_model_%0d a=%h/%h b=%h/%h", i, va, expv(ma), vb, expv(mb)); end
    end
    checks++;
    if (sc_a !== 10'd50 || bl_a !== 4'd8 || sc_b !== 6'd50) begin errors++; $display("FAIL simul_hold score=%0d balls=%0d exp 50/8", sc_a, bl_a); end
    in_v = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (bl_a !== 4'd8 || sc_a !== 10'd50) begin errors++; $display("FAIL simul_fall score=%0d balls=%0d exp 50/8", sc_a, bl_a); end
  endtask
  task automatic test_saturate_start();
    do_reset();
    pulse(8'h02, 1, 3);
    pulse(8'h40, 1, 3);
    checks++;
    if (sc_b !== 6'd50) begin errors++; $display("FAIL sat_first score=%0d exp 50", sc_b); end
    pulse(8'h40, 1, 3);
    checks++;
    if (sc_b !== 6'd63 || sc_a !== 10'd100) begin errors++; $display("FAIL sat_second score_b=%0d score_a=%0d exp 63/100", sc_b, sc_a); end
    pulse(8'h02, 1, 3);
    checks++;
    if (sc_a !== 10'd100 || bl_a !== 4'd7 || st_a !== 2'b01 || tl_a !== 7'd60) begin errors++; $display("FAIL start_in_play score=%0d balls=%0d time=%0d exp 100/7/60", sc_a, bl_a, tl_a); end
    repeat (3) pulse(8'h01, 1, 3);
    pulse(8'h02, 1, 3);
    checks++;
    if (st_b !== 2'b10 || tl_b !== 7'd5 || sc_b !== 6'd63 || bl_b !== 4'd7) begin errors++; $display("FAIL start_in_over st=%0d time=%0d score=%0d exp 2/5/63", st_b, tl_b, sc_b); end
    checks++;
    if (va !== expv(ma) || vb !== expv(mb)) begin errors++; $display("FAIL sat_model a=%h/%h b=%h/%h", va, expv(ma), vb, expv(mb)); end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      checks++;
      if (va !== expv(ma) || vb !== expv(mb)) begin errors++; $display("FAIL random_%0d a=%h/%h b=%h/%h", c, va, expv(ma), vb, expv(mb)); end
      for (int i = 0; i < 8; i++) if ($urandom_range(0, i == 0 ? 7 : 23) == 0) in_v[i] = ~in_v[i];
    end
  endtask
  initial begin
    test_reset();
    test_scoring();
    test_ball_limit();
    test_timeout();
    test_simultaneous();
    test_saturate_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
